// File: rtl/l2_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter_if
// Bundles the two L1 client ports and the single L2Cache port that the
// arbiter sits between.
//   c0_* : ICache client (req/addr/burst/wdata in, rdata/busy out)
//   c1_* : DCache client (req/addr/burst/wdata in, rdata/busy out)
//   l2_* : L2Cache request port (req/addr/burst/wdata out, rdata/busy in)
// Modports:
//   master : the environment (L1 clients plus L2Cache)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface l2_port_arbiter_if;
  logic        c0_rreq;
  logic        c0_wreq;
  logic [31:0] c0_addr;
  logic [4:0]  c0_burst_size;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic        c0_busy;

  logic        c1_rreq;
  logic        c1_wreq;
  logic [31:0] c1_addr;
  logic [4:0]  c1_burst_size;
  logic [31:0] c1_wdata;
  logic [31:0] c1_rdata;
  logic        c1_busy;

  logic        l2_rreq;
  logic        l2_wreq;
  logic [31:0] l2_addr;
  logic [4:0]  l2_burst_size;
  logic [31:0] l2_wdata;
  logic [31:0] l2_rdata;
  logic        l2_busy;

  modport master (
    output c0_rreq, c0_wreq, c0_addr, c0_burst_size, c0_wdata,
    input  c0_rdata, c0_busy,
    output c1_rreq, c1_wreq, c1_addr, c1_burst_size, c1_wdata,
    input  c1_rdata, c1_busy,
    input  l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata,
    output l2_rdata, l2_busy
  );

  modport slave (
    input  c0_rreq, c0_wreq, c0_addr, c0_burst_size, c0_wdata,
    output c0_rdata, c0_busy,
    input  c1_rreq, c1_wreq, c1_addr, c1_burst_size, c1_wdata,
    output c1_rdata, c1_busy,
    output l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata,
    input  l2_rdata, l2_busy
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
// Shares the single L2Cache request port between the ICache (port 0) and the
// DCache (port 1). A whole transaction is granted at a time; the grant is
// registered, so the L2 sees a request one cycle after the client raises it,
// and every transaction is followed by one idle turnaround cycle.
// Ties are broken round-robin, or always in favour of port 1 when
// FIXED_PRIO=1. Per-port saturating grant counters are exported.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   bus        : client/L2 bundle (slave modport)
//   grant_cnt0 : grants issued to port 0 (saturating)
//   grant_cnt1 : grants issued to port 1 (saturating)
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  l2_port_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]     grant_cnt0,
  output logic [CNT_W-1:0]     grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_req0;
  logic             w_req1;
  logic             w_enter0;
  logic             w_enter1;

  assign w_req0 = bus.c0_rreq | bus.c0_wreq;
  assign w_req1 = bus.c1_rreq | bus.c1_wreq;

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

  // Next-state selection: grants are only decided from IDLE, so a granted
  // client can never be preempted while its request is held.
  always_comb begin
    w_next   = r_state;
    w_enter0 = 1'b0;
    w_enter1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          if (FIXED_PRIO != 0) begin
            w_next = G1;
          end else if (r_last) begin
            w_next = G0;
          end else begin
            w_next = G1;
          end
        end else if (w_req0) begin
          w_next = G0;
        end else if (w_req1) begin
          w_next = G1;
        end else begin
          w_next = IDLE;
        end
        w_enter0 = (w_next == G0);
        w_enter1 = (w_next == G1);
      end
      G0: begin
        if (w_req0) begin
          w_next = G0;
        end else begin
          w_next = IDLE;
        end
      end
      G1: begin
        if (w_req1) begin
          w_next = G1;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Output steering: the granted client talks straight to the L2, the other
  // one is stalled by its own request. IDLE ignores l2_busy entirely.
  always_comb begin
    bus.l2_rreq       = 1'b0;
    bus.l2_wreq       = 1'b0;
    bus.l2_addr       = 32'd0;
    bus.l2_burst_size = 5'd0;
    bus.l2_wdata      = 32'd0;
    bus.c0_rdata      = 32'd0;
    bus.c1_rdata      = 32'd0;
    bus.c0_busy       = w_req0;
    bus.c1_busy       = w_req1;
    case (r_state)
      G0: begin
        bus.l2_rreq       = bus.c0_rreq;
        bus.l2_wreq       = bus.c0_wreq;
        bus.l2_addr       = bus.c0_addr;
        bus.l2_burst_size = bus.c0_burst_size;
        bus.l2_wdata      = bus.c0_wdata;
        bus.c0_rdata      = bus.l2_rdata;
        bus.c0_busy       = bus.l2_busy;
      end
      G1: begin
        bus.l2_rreq       = bus.c1_rreq;
        bus.l2_wreq       = bus.c1_wreq;
        bus.l2_addr       = bus.c1_addr;
        bus.l2_burst_size = bus.c1_burst_size;
        bus.l2_wdata      = bus.c1_wdata;
        bus.c1_rdata      = bus.l2_rdata;
        bus.c1_busy       = bus.l2_busy;
      end
      IDLE: begin
        bus.l2_rreq = 1'b0;
      end
      default: begin
        bus.l2_rreq = 1'b0;
      end
    endcase
  end

  // State, round-robin pointer and saturating grant counters. The async
  // reset returns to IDLE, which withdraws any L2 request immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt0  <= {CNT_W{1'b0}};
      r_cnt1  <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_enter0) begin
        r_last <= 1'b0;
        if (r_cnt0 != CNT_MAX) begin
          r_cnt0 <= r_cnt0 + CNT_ONE;
        end
      end
      if (w_enter1) begin
        r_last <= 1'b1;
        if (r_cnt1 != CNT_MAX) begin
          r_cnt1 <= r_cnt1 + CNT_ONE;
        end
      end
    end
  end

endmodule
